// File: rtl/nn_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : nn_param_loader
// Brief    : Assembles a word-serial weight/bias stream in a staging register
//            and commits the complete parameter set atomically to the decoder.
// Revision : 1.0
// ============================================================================
module nn_param_loader #(
    parameter int N_INPUTS    = 4,
    parameter int N_LAYER_1   = 2,
    parameter int N_LAYER_2   = 2,
    parameter int WEIGHT_BITS = 3,
    localparam int N_W = N_INPUTS*N_LAYER_1 + N_LAYER_1*N_LAYER_2 + N_LAYER_2*2,
    localparam int N_B = N_LAYER_1 + N_LAYER_2 + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WEIGHT_BITS-1:0]     s_data,
    input  logic                       s_last,
    output logic [N_W*WEIGHT_BITS-1:0] weights,
    output logic [N_B*WEIGHT_BITS-1:0] bias,
    output logic                       params_valid,
    output logic                       params_update,
    output logic                       busy,
    output logic                       error
);

    localparam int N_MAX = (N_W > N_B) ? N_W : N_B;
    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam logic [CNT_W-1:0] c_w_last = CNT_W'(N_W - 1);
    localparam logic [CNT_W-1:0] c_b_last = CNT_W'(N_B - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_B = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             w_cnt_next;
    logic [N_W*WEIGHT_BITS-1:0]   r_stage_w;
    logic [N_B*WEIGHT_BITS-1:0]   r_stage_b;
    logic [N_B*WEIGHT_BITS-1:0]   w_bias_merged;
    logic [N_W*WEIGHT_BITS-1:0]   r_weights;
    logic [N_B*WEIGHT_BITS-1:0]   r_bias;
    logic                         r_params_valid;
    logic                         r_params_update;
    logic                         r_error;
    logic                         w_xfer;
    logic                         w_commit;
    logic                         w_frame_err;

    // A coincident start wins over the word on the bus, so the word is refused.
    assign s_ready = (r_state != ST_IDLE) && !start;
    assign w_xfer  = s_valid && s_ready;

    assign weights       = r_weights;
    assign bias          = r_bias;
    assign params_valid  = r_params_valid;
    assign params_update = r_params_update;
    assign busy          = (r_state != ST_IDLE);
    assign error         = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        w_frame_err  = 1'b0;
        if (start) begin
            w_state_next = ST_LOAD_W;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_LOAD_W: begin
                    if (w_xfer) begin
                        if (s_last) begin
                            w_frame_err  = 1'b1;
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_w_last) begin
                            w_state_next = ST_LOAD_B;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (w_xfer) begin
                        if (r_cnt == c_b_last) begin
                            w_commit     = s_last;
                            w_frame_err  = !s_last;
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else if (s_last) begin
                            w_frame_err  = 1'b1;
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Bias staging with the word on the bus folded in, so the final bias word
    // reaches the committed outputs on the same edge it is accepted.
    always_comb begin
        w_bias_merged = r_stage_b;
        for (int j = 0; j < N_B; j++) begin
            if (r_cnt == CNT_W'(j)) begin
                w_bias_merged[j*WEIGHT_BITS +: WEIGHT_BITS] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_w <= '0;
            r_stage_b <= '0;
        end else if (w_xfer) begin
            if (r_state == ST_LOAD_W) begin
                for (int k = 0; k < N_W; k++) begin
                    if (r_cnt == CNT_W'(k)) begin
                        r_stage_w[k*WEIGHT_BITS +: WEIGHT_BITS] <= s_data;
                    end
                end
            end else if (r_state == ST_LOAD_B) begin
                r_stage_b <= w_bias_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_weights       <= '0;
            r_bias          <= '0;
            r_params_valid  <= 1'b0;
            r_params_update <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_params_update <= w_commit;
            if (w_commit) begin
                r_weights      <= r_stage_w;
                r_bias         <= w_bias_merged;
                r_params_valid <= 1'b1;
            end
            if (start) begin
                r_error <= 1'b0;
            end else if (w_frame_err) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
